// File: rtl/booth_prod_accum_pkg.sv
// Shared definitions for the framed product accumulator.
// Holds the frame state encoding and the default widths / clamp bounds
// used by booth_prod_accum and booth_sat_add.
package booth_prod_accum_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int CNT_W_DEF  = 4;

  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};
  localparam logic [CNT_W_DEF-1:0]        CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } frame_state_t;

endpackage

// File: rtl/booth_sat_add.sv
// Combinational saturating adder: ACC_W-bit signed accumulator plus a
// DATA_W-bit signed operand, clamped to the ACC_W signed range.
// Ports:
//   acc     in  ACC_W   current accumulator
//   operand in  DATA_W  signed addend
//   sum     out ACC_W   clamped result
//   ovf     out 1       result was clamped
module booth_sat_add
  import booth_prod_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] operand,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] sum_wide;

  // One guard bit is enough: the operand is narrower than the accumulator.
  assign sum_wide = {acc[ACC_W-1], acc}
                  + {{(ACC_W+1-DATA_W){operand[DATA_W-1]}}, operand};

  always_comb begin
    ovf = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum = sum_wide[ACC_W-1:0];
    if (ovf) begin
      sum = sum_wide[ACC_W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/booth_prod_accum.sv
// Framed saturating product accumulator. Sums each in_last-terminated
// frame of signed products and hands the total out through a
// single-entry output register with valid/ready.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input beat handshake
//   in_data, in_last           signed product, end-of-frame marker
//   out_valid/out_ready        output total handshake
//   out_sum, out_sat, out_cnt  frame total, sticky clamp flag, beat count
//
// state | meaning
// IDLE  | between frames; acc/sat/cnt are zero
// RUN   | mid-frame; acc/sat/cnt hold the partial sum
module booth_prod_accum
  import booth_prod_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_cnt
);

  frame_state_t     state;
  logic [ACC_W-1:0] acc;
  logic             sat;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W-1:0] acc_base;
  logic             sat_base;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             accept;

  // Stalls only while a held total is not draining, so a new last beat
  // can reload the register on the same edge it empties.
  assign in_ready = !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  // A frame always starts from zero, whatever the registers hold.
  assign acc_base = (state == IDLE) ? '0   : acc;
  assign sat_base = (state == IDLE) ? 1'b0 : sat;
  assign cnt_base = (state == IDLE) ? '0   : cnt;
  assign cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);

  // Shared by the mid-frame and last-beat paths.
  booth_sat_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .acc     (acc_base),
    .operand (in_data),
    .sum     (add_sum),
    .ovf     (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      sat       <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      out_cnt   <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (in_last) begin
          out_sum   <= add_sum;
          out_sat   <= sat_base | add_ovf;
          out_cnt   <= cnt_next;
          out_valid <= 1'b1;
          acc       <= '0;
          sat       <= 1'b0;
          cnt       <= '0;
          state     <= IDLE;
        end else begin
          acc   <= add_sum;
          sat   <= sat_base | add_ovf;
          cnt   <= cnt_next;
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_prod_accum.sv
module tb_booth_prod_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_sat;
  logic [3:0]  out_cnt;

  typedef struct packed {
    logic [15:0] sum;
    logic        sat;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  booth_prod_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sat   (out_sat),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int sum, input bit sat, input int cnt);
    exp_t e;
    e.sum = sum[15:0];
    e.sat = sat;
    e.cnt = cnt[3:0];
    exp_q.push_back(e);
  endtask

  // Monitor: a total transfers at the next rising edge when both
  // handshake signals are high at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      pop_cyc.push_back(cycle);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_total: got sum %0h with empty queue", out_sum);
      end else begin
        e = exp_q.pop_front();
        chk("out_sum", 32'(out_sum), 32'(e.sum));
        chk("out_sat", 32'(out_sat), 32'(e.sat));
        chk("out_cnt", 32'(out_cnt), 32'(e.cnt));
      end
    end
  end

  // Drive a beat and hold it until accepted; returns cycles spent stalled.
  task automatic send(input int d, input bit l, output int stalls);
    in_valid = 1'b1;
    in_data  = d[7:0];
    in_last  = l;
    stalls   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      stalls++;
      if (stalls > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck at 0 expected 1");
        break;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int total_stall;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_out_cnt",   32'(out_cnt),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 5, -3, 7 -> 9
    push_exp(9, 0, 3);
    send(5, 0, s);
    send(-3, 0, s);
    send(7, 1, s);
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("single_cycle_valid", 32'(out_valid), 32'd0);

    // Positive saturation, then sticky flag cleared by the next frame
    push_exp(32767, 1, 15);
    push_exp(1, 0, 1);
    for (int i = 0; i < 300; i++) send(127, 0, s);
    send(127, 1, s);
    send(1, 1, s);
    idle();

    // Negative saturation, then a single-beat negative frame
    push_exp(-32768, 1, 15);
    push_exp(-128, 0, 1);
    for (int i = 0; i < 300; i++) send(-128, 0, s);
    send(-128, 1, s);
    send(-128, 1, s);
    idle();
    repeat (2) @(posedge clk); #1;

    // Backpressure: A held, B stalls
    out_ready = 1'b0;
    push_exp(10, 0, 1);
    push_exp(10, 0, 2);
    send(10, 1, s);
    in_valid = 1'b1;
    in_data  = 8'd4;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready",  32'(in_ready),  32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_sum",   32'(out_sum),   32'd10);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4, 0, s);
    send(6, 1, s);
    idle();
    repeat (2) @(posedge clk); #1;

    // Back-to-back single-beat frames
    pop_cyc.delete();
    push_exp(1, 0, 1);
    push_exp(2, 0, 1);
    push_exp(3, 0, 1);
    total_stall = 0;
    send(1, 1, s); total_stall += s;
    send(2, 1, s); total_stall += s;
    send(3, 1, s); total_stall += s;
    idle();
    repeat (2) @(posedge clk); #1;
    chk("b2b_stalls", 32'(total_stall), 32'd0);
    chk("b2b_count", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      chk("b2b_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      chk("b2b_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
    end

    // Reset mid-frame discards the partial sum
    send(50, 0, s);
    send(50, 0, s);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    push_exp(7, 0, 1);
    send(7, 1, s);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_prod_accum.md
# booth_prod_accum

Downstream consumer of the 8-bit signed Booth multiplier result. It collects a framed stream of signed products and sums each frame into a wide saturating accumulator. It then presents one frame total per output handshake, so a multiplier followed by this block forms a dot-product / MAC unit. Input and output both use valid/ready; partial sums are never exposed.

## Interface
- DATA_W, 8, width of each signed product beat
- ACC_W, 16, width of signed accumulator and frame total (ACC_W > DATA_W)
- CNT_W, 4, width of the per-frame beat counter (saturating)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low (one clock; polarity and synchronicity fixed)
- in_valid  in  1  product beat present
- in_ready  out  1  block accepts beat this cycle
- in_data  in  DATA_W  signed product (two's complement)
- in_last  in  1  beat is final of frame
- out_valid  out  1  frame total held
- out_ready  in  1  consumer takes total this cycle
- out_sum  out  ACC_W  signed saturated frame total
- out_sat  out  1  saturation occurred anywhere in frame (sticky per frame)
- out_cnt  out  CNT_W  beats in frame, saturating at 2^CNT_W-1

## Operation
- Beat accepted when in_valid && in_ready at a rising edge.
- Each beat: in_data sign-extended to ACC_W+1, added to acc. Result clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; clamp sets sticky sat.
- Beat counter increments per accepted beat, sticks at all-ones.
- States:
  - IDLE: acc=0, sat=0, cnt=0; first accepted beat -> RUN, or stays IDLE if in_last.
  - RUN: mid-frame; accepted non-last beats stay RUN; accepted last beat -> IDLE.
- On accepted last beat: saturated (acc + in_data), final sat and cnt (incl. this beat) load into output register; out_valid=1. Same edge: acc/sat/cnt cleared for next frame.
- in_ready = !(out_valid && !out_ready): only blocks while output register is full and not draining. Non-last beats stall too (deliberate, keeps rule single-term).
- Output register single entry; out_sum/out_sat/out_cnt stable while out_valid && !out_ready.
- Simultaneous drain (out_valid && out_ready) and new last beat: register reloads with new frame, out_valid stays 1.
- in_last on the very first beat of a frame is legal: total = sign-extended in_data, cnt=1.
- in_data/in_last ignored when not accepted.

## Timing
- Latency: last beat accepted at edge k -> out_valid=1 from edge k (visible cycle after k).
- Throughput: one beat per cycle; one frame per cycle when consumer keeps out_ready=1.
- in_ready is combinational from out_valid and out_ready only; no path from in_valid.
- Reset (async assert, sync-safe deassert): state=IDLE, acc=0, sat=0, cnt=0, out_valid=0, out_sum=0, out_sat=0, out_cnt=0; in_ready=1.
- Reset mid-frame or with out_valid=1: partial frame and held total discarded, no output produced.

## Structure
- Shared package: state enum (IDLE, RUN), ACC_MAX/ACC_MIN constants derived from ACC_W, CNT_MAX.
- One sub-module: booth_sat_add (combinational, ACC_W accumulator + DATA_W signed operand -> clamped sum + overflow flag), reused for per-beat and last-beat paths.

## Test plan
- Frame 5, -3, 7(last), out_ready=1 -> out_sum=9, out_sat=0, out_cnt=3, out_valid one cycle.
- 300 beats of 127 then last -> out_sum=32767, out_sat=1, out_cnt=15; next frame 1(last) -> out_sum=1, out_sat=0 (sticky cleared).
- 300 beats of -128 -> out_sum=-32768, out_sat=1; single-beat frame -128(last) -> out_sum=-128, out_cnt=1.
- out_ready=0, frame A=10(last) held, frame B beat 4 offered -> in_ready=0, out_sum stays 10. Raise out_ready -> A drains; B=4, 6(last) -> 10.
- Back-to-back single-beat frames 1,2,3 with out_ready=1 -> totals 1,2,3 on consecutive cycles, in_ready constant 1.
- rst_n low after beats 50, 50 (no last) -> out_valid=0; after release frame 7(last) -> out_sum=7, out_cnt=1.
